// File: rtl/p_logic_pkg.sv
// Shared encodings and FSM state type for the sequential boolean reducers.
package p_logic_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    // NAND folds as AND; the inversion is applied once on the final result.
    function automatic logic [1:0] fold_op(input logic [1:0] op);
        return (op == OP_NAND) ? OP_AND : op;
    endfunction

endpackage

// File: rtl/p_logic_op.sv
// Two-operand bitwise AND/OR/XOR selected by op; any other code acts as AND.
module p_logic_op
    import p_logic_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic [1:0]           op,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] y_c
);

    // Select the bitwise operation.
    always_comb begin
        y_c = a & b;
        case (op)
            OP_OR:   y_c = a | b;
            OP_XOR:  y_c = a ^ b;
            default: y_c = a & b;
        endcase
    end

endmodule

// File: rtl/p_reduce_seq.sv
// Sequential NB_INS-operand bitwise reducer with valid/ready input and output streams.
module p_reduce_seq
    import p_logic_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned NB_INS    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [1:0]           op,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(NB_INS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_INS - 1);
    localparam bit SINGLE = (NB_INS == 1);

    state_t               state;
    state_t               next_state;
    logic [BUS_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           op_q;

    logic                 beat_c;
    logic                 take_c;
    logic                 last_c;
    logic [1:0]           step_op_c;
    logic [BUS_WIDTH-1:0] fold_c;
    logic [BUS_WIDTH-1:0] raw_c;
    logic [1:0]           res_op_c;
    logic [BUS_WIDTH-1:0] result_c;

    logic                 in_ready_d;
    logic                 out_valid_d;
    logic                 busy_d;

    assign beat_c    = in_valid & in_ready;
    assign take_c    = out_valid & out_ready;
    assign last_c    = (cnt == LAST_CNT);
    assign step_op_c = fold_op(op_q);

    p_logic_op #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_fold (
        .op  (step_op_c),
        .a   (acc),
        .b   (in_data),
        .y_c (fold_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every other event.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_c) begin
                        next_state = SINGLE ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_c && last_c) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    if (take_c) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Handshake/status outputs derived from the upcoming state.
    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (next_state)
            ACCUM: begin
                busy_d = 1'b1;
            end
            DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Registered handshake/status outputs, so they depend only on state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Final value for the beat that completes a reduction (first beat when NB_INS==1).
    always_comb begin
        raw_c    = fold_c;
        res_op_c = op_q;
        if (state == IDLE) begin
            raw_c    = in_data;
            res_op_c = op;
        end
        result_c = (res_op_c == OP_NAND) ? ~raw_c : raw_c;
    end

    // Accumulator, beat counter, latched op and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            op_q     <= OP_AND;
            out_data <= '0;
        end else if (flush) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_c) begin
                        acc  <= in_data;
                        op_q <= op;
                        if (SINGLE) begin
                            cnt      <= '0;
                            out_data <= result_c;
                        end else begin
                            cnt <= CNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (beat_c) begin
                        acc <= fold_c;
                        if (last_c) begin
                            cnt      <= '0;
                            out_data <= result_c;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (take_c) begin
                        out_data <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_reduce_seq.sv
// Self-checking bench for p_reduce_seq: directed cases plus randomized reductions vs a reference model.
module tb_p_reduce_seq;
    import p_logic_pkg::*;

    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          flush = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          busy;

    logic          s_flush = 1'b0;
    logic [1:0]    s_op = 2'b00;
    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [BW-1:0] s_in_data = '0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b0;
    logic [BW-1:0] s_out_data;
    logic          s_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [BW-1:0] q[$];

    always #5 clk = ~clk;

    p_reduce_seq #(.BUS_WIDTH(BW), .NB_INS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    p_reduce_seq #(.BUS_WIDTH(BW), .NB_INS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .op(s_op),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: fold all operands with the first-beat op, invert once for NAND.
    function automatic logic [BW-1:0] model(input logic [1:0] o, input logic [BW-1:0] b[$]);
        logic [BW-1:0] r;
        r = b[0];
        for (int i = 1; i < b.size(); i++) begin
            if (o == 2'b01)      r = r | b[i];
            else if (o == 2'b10) r = r ^ b[i];
            else                 r = r & b[i];
        end
        return (o == 2'b11) ? ~r : r;
    endfunction

    // One full reduction on the NB_INS=3 instance with optional gaps, op toggling and output stall.
    task automatic reduce3(input string tag, input logic [1:0] o, input logic [BW-1:0] b[$],
                           input logic [BW-1:0] exp, input int gap, input bit rand_gap,
                           input bit toggle, input int stall);
        int g;
        out_ready = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            if (i > 0) begin
                g = rand_gap ? int'($urandom_range(32'(gap), 0)) : gap;
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_data  = BW'($urandom);
                    check({tag, " gap in_ready"}, 32'(in_ready), 32'd1);
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = b[i];
            op       = (i == 0 || !toggle) ? o : 2'($urandom);
            check({tag, " early out_valid"}, 32'(out_valid), 32'd0);
            check({tag, " beat in_ready"}, 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = BW'($urandom);
        op       = 2'($urandom);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_data"}, 32'(out_data), 32'(exp));
        check({tag, " done in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " done busy"}, 32'(busy), 32'd1);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            step();
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall out_data"}, 32'(out_data), 32'(exp));
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post busy"}, 32'(busy), 32'd0);
        check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One reduction on the NB_INS=1 instance.
    task automatic reduce1(input string tag, input logic [1:0] o, input logic [BW-1:0] d,
                           input logic [BW-1:0] exp);
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = d;
        s_op        = o;
        check({tag, " in_ready"}, 32'(s_in_ready), 32'd1);
        step();
        s_in_valid = 1'b0;
        s_in_data  = BW'($urandom);
        check({tag, " out_valid"}, 32'(s_out_valid), 32'd1);
        check({tag, " out_data"}, 32'(s_out_data), 32'(exp));
        step();
        check({tag, " drop"}, 32'(s_out_valid), 32'd0);
        s_out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]    ro;
        logic [BW-1:0] rd;

        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        #11 rst_n = 1'b1;
        step();
        check("rel in_ready", 32'(in_ready), 32'd1);
        check("rel out_valid", 32'(out_valid), 32'd0);

        q = {8'hF0, 8'hCC, 8'hAA};
        reduce3("and", OP_AND, q, 8'h80, 0, 1'b0, 1'b0, 0);
        q = {8'h01, 8'h02, 8'h04};
        reduce3("or_gaps", OP_OR, q, 8'h07, 2, 1'b0, 1'b0, 0);
        q = {8'hFF, 8'h0F, 8'h33};
        reduce3("xor_toggle", OP_XOR, q, 8'hC3, 0, 1'b0, 1'b1, 0);
        q = {8'hF0, 8'hCC, 8'hAA};
        reduce3("nand_stall", OP_NAND, q, 8'h7F, 0, 1'b0, 1'b0, 5);

        // Flush after two beats, with a competing beat in the flush cycle.
        op = OP_XOR; in_valid = 1'b1; in_data = 8'hAA; step();
        in_data = 8'h55; step();
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1; in_data = 8'h0F; step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        step();
        check("flush no result", 32'(out_valid), 32'd0);
        q = {8'h10, 8'h20, 8'h40};
        reduce3("after_flush", OP_OR, q, 8'h70, 0, 1'b0, 1'b0, 0);

        // Flush in the same cycle as the output handshake.
        op = OP_OR; in_valid = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_data = 8'h04; step();
        in_valid = 1'b0;
        check("fo done", 32'(out_valid), 32'd1);
        flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0; out_ready = 1'b0;
        check("fo out_valid", 32'(out_valid), 32'd0);
        check("fo busy", 32'(busy), 32'd0);
        check("fo in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of a reduction.
        op = OP_AND; in_valid = 1'b1; in_data = 8'h3C; step();
        in_valid = 1'b0;
        check("arst pre busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst out_data", 32'(out_data), 32'd0);
        check("arst in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        step();
        q = {8'hF0, 8'hCC, 8'hAA};
        reduce3("after_arst", OP_AND, q, 8'h80, 0, 1'b0, 1'b0, 0);

        reduce1("n1_and", OP_AND, 8'h5A, 8'h5A);
        reduce1("n1_nand", OP_NAND, 8'h5A, 8'hA5);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            q = {};
            for (int i = 0; i < 3; i++) q.push_back(BW'($urandom));
            reduce3("rand3", ro, q, model(ro, q), 3, 1'b1, 1'b1, int'($urandom_range(3, 0)));
        end
        for (int n = 0; n < 10; n++) begin
            ro = 2'($urandom);
            rd = BW'($urandom);
            q = {rd};
            reduce1("rand1", ro, rd, model(ro, q));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p_reduce_seq.md
Name: p_reduce_seq

Overview:
Sequential, parametrised multi-operand bitwise reducer and successor to the combinational parametrised gate blocks. It accepts NB_INS operand buses one per beat over a valid/ready stream. It folds them with a selectable operation (AND/OR/XOR/NAND) into an accumulator, then presents the result on a valid/ready output. It sits in the boolean library and serves datapath blocks that cannot afford NB_INS parallel bus inputs.

Parameters:
BUS_WIDTH, 8, width of each operand and of the result in bits (>=1)
NB_INS, 4, operands per reduction (>=1)
CNT_W, $clog2(NB_INS+1), width of the beat counter (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort: drop any partial or pending result
op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled only on the first beat
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts an operand this cycle
in_data  input  BUS_WIDTH  operand bus
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  BUS_WIDTH  reduction result
busy  output  1  reduction in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, cnt=0, op_q=00.
  - Outputs: out_valid=0, out_data=0, busy=0, in_ready=1 once rst_n is released.
- An operand beat is accepted when in_valid & in_ready at a rising edge. A result is taken when out_valid & out_ready.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE:
    - in_ready=1.
    - On a beat: acc<=in_data, op_q<=op, cnt<=1.
    - Next state: DONE if NB_INS==1, else ACCUM.
  - ACCUM:
    - in_ready=1.
    - On a beat: acc<=acc OP in_data (AND/OR/XOR per op_q; NAND accumulates as AND), cnt<=cnt+1.
    - If cnt==NB_INS-1 on that beat, go to DONE.
    - No beat: hold.
  - DONE:
    - in_ready=0, out_valid=1.
    - out_data=acc, or ~acc when op_q==NAND.
    - out_data is stable while out_valid=1 and out_ready=0.
    - On out_ready: go to IDLE, out_valid=0 next cycle.
- Timing:
  - Latency: out_valid asserts the cycle after the last operand is accepted.
  - Minimum period per reduction: NB_INS+1 cycles. No overlap of consecutive reductions (DONE blocks input).
- Operation sampling:
  - op changes after the first beat are ignored until the next reduction.
  - in_data is ignored when in_valid=0.
- flush:
  - Any state goes to IDLE next edge; acc and cnt are cleared; out_valid drops.
  - flush has priority over a simultaneous beat or out_ready. The simultaneous beat is discarded, and a result handshaken in the same cycle is considered not delivered.
- Counter: cnt never exceeds NB_INS-1 and does not wrap.
- Reset asserted mid-reduction: immediate return to reset values; the partial result is lost, with no output pulse.
- Combinational paths: in_ready and out_valid are pure functions of state. There is no combinational path from in_valid or out_ready to any output.

Decomposition:
- Package p_logic_pkg:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
  - FSM state typedef {IDLE, ACCUM, DONE}.
- Sub-module p_logic_op: combinational two-operand BUS_WIDTH-wide AND/OR/XOR selected by op. It is instantiated once for the accumulate step and is reusable by other boolean blocks.
- Output inversion for NAND stays in the top level.

Test Plan:
- BUS_WIDTH=8, NB_INS=3, op=AND, beats 0xF0, 0xCC, 0xAA back-to-back, out_ready=1 -> out_data=0x80, out_valid high exactly one cycle, on the cycle after the third beat.
- op=OR, beats 0x01, 0x02, 0x04 with in_valid gaps of 2 idle cycles between beats -> out_data=0x07. in_ready stays high through the gaps and drops in DONE.
- op=XOR, beats 0xFF, 0x0F, 0x33, op toggled to AND after the first beat -> out_data=0xC3; the toggle is ignored.
- op=NAND, beats 0xF0, 0xCC, 0xAA, out_ready held 0 for 5 cycles -> out_valid=1 and out_data=0x7F stable for 5 cycles; in_ready=0 throughout; the next reduction starts only after the handshake.
- flush asserted after 2 beats, then a new OR reduction 0x10, 0x20, 0x40 -> the first reduction produces no output; the second gives 0x70. Also flush in the same cycle as out_ready -> out_valid=0 next cycle, state IDLE.
- rst_n pulsed low asynchronously (mid-cycle) during ACCUM -> outputs return to reset values immediately; a full reduction then proceeds correctly. Repeat the AND test with NB_INS=1: beat 0x5A -> out_data=0x5A after 1 cycle.
